input_sample_buffer: RTL and testbench
======================================

# input_sample_buffer

Parametrised multi-channel circular input-sample buffer for the MSDAP datapath. It sits between the serial input front end and the FIR/MAC engine. It holds the most recent DEPTH samples per channel and serves reads by sample age (x[n-k]). It clears itself with a sequencer after reset or `start`, and raises a per-channel sleep flag after a programmable run of consecutive zero samples.

## Interface
- `DATA_W`, 16, sample width in bits.
- `DEPTH`, 256, samples per channel; must be a power of two, at least 4.
- `NCH`, 2, channel count (at least 1).
- `SLEEP_THRESH`, 800, number of consecutive zero writes that asserts sleep; range 1 to 2^16-1.
- Derived: `AW` = log2(DEPTH); `CW` = max(1, log2(NCH)).
- `sClk`, in, 1, sole clock; all logic on rising edge.
- `reset`, in, 1, synchronous, active-high.
- `start`, in, 1, synchronous restart; same effect as `reset` on state, memory and outputs.
- `wr_En`, in, 1, write strobe (one sample per cycle).
- `wr_Ch`, in, CW, write channel.
- `data_In`, in, DATA_W, write sample.
- `rd_En`, in, 1, read strobe.
- `rd_Ch`, in, CW, read channel.
- `rd_Offset`, in, AW, sample age: 0 = newest sample.
- `data_Out`, out, DATA_W, registered read data.
- `data_Valid`, out, 1, one-cycle pulse qualifying `data_Out`.
- `w_Done`, out, 1, one-cycle pulse acknowledging an accepted write.
- `busy`, out, 1, high while the clear sequence runs.
- `sleep`, out, NCH, per-channel sleep flag.
- `sleep_All`, out, 1, AND of all `sleep` bits.

## Operation
- FSM with two states: CLEAR and RUN.
  - `reset` or `start` forces CLEAR from any state and zeroes the clear counter, all write pointers and all zero-run counters.
  - CLEAR writes 0 to address `clr_cnt` in every channel each cycle. After `clr_cnt` = DEPTH-1 it moves to RUN.
  - RUN is held until the next `reset` or `start`.
- Write (RUN, `wr_En`=1):
  - `mem[wr_Ch][wr_ptr[wr_Ch]]` <= `data_In`.
  - `wr_ptr[wr_Ch]` increments modulo DEPTH (natural wrap). The oldest sample is silently overwritten and there is no full flag.
- Read (RUN, `rd_En`=1): address = (`wr_ptr[rd_Ch]` - 1 - `rd_Offset`) mod DEPTH.
  - Ages beyond the number of samples written since the clear return 0.
- Simultaneous read and write to the same channel: the read uses the pre-write pointer, so offset 0 returns the previous newest sample, not `data_In`.
- `wr_Ch` or `rd_Ch` ≥ NCH: the operation is ignored and no pulse is generated.
- In CLEAR, `wr_En` and `rd_En` are ignored; `w_Done` and `data_Valid` stay 0.
- Zero-run counter per channel (16-bit, saturating at SLEEP_THRESH):
  - A write of 0 increments the counter.
  - A non-zero write clears the counter and `sleep[ch]`.
  - `sleep[ch]` is set when the counter reaches SLEEP_THRESH and stays set until a non-zero write, `reset` or `start`.

## Timing
- Reset values (cycle after `reset` or `start`): `data_Out`=0, `data_Valid`=0, `w_Done`=0, `sleep`=0, `sleep_All`=0, `busy`=1.
- CLEAR lasts exactly DEPTH cycles. `busy` falls the cycle after the last clear write; the first write is accepted on that cycle.
- Write: `w_Done` is high exactly one cycle, the cycle after `wr_En` is sampled. Back-to-back writes give back-to-back pulses.
- Read latency is 1 cycle: `data_Out` and `data_Valid` update the cycle after `rd_En`. `data_Out` holds its value when `data_Valid`=0.
- Sleep: `sleep[ch]` rises the cycle after the SLEEP_THRESH-th consecutive zero write, and falls the cycle after a non-zero write.
- `reset` or `start` mid-clear restarts the clear from address 0. Mid-RUN, any pending pulses are dropped.

## Configuration
- `INPUT_BUF_SLEEP_DET_EN` defined: zero-run counters and the `sleep`/`sleep_All` logic are compiled in as described.
- Not defined: counters are removed and `sleep`/`sleep_All` are tied to 0. All other behaviour is unchanged.

## Test plan
- Reset then idle: `busy`=1 for 256 cycles, then 0. Read ch0 offset 0 returns 0x0000 with `data_Valid` pulsed.
- Write ch0 samples 1..300, then read offsets 0, 1 and 255 -> 300, 299 and 45. `w_Done` is pulsed once per write.
- Interleave writes ch0=0x1111 and ch1=0x2222, then read both at offset 0 -> 0x1111 and 0x2222; there is no cross-channel effect.
- Same-cycle write 0xAAAA and read ch0 offset 0 after a prior write of 0x5555 -> read returns 0x5555. The next read returns 0xAAAA.
- With `INPUT_BUF_SLEEP_DET_EN`: 800 zero writes to ch1 -> `sleep[1]` rises after the 800th write. A write of 0x0001 clears it the next cycle. Zero runs on both channels raise `sleep_All`.
- Assert `start` at cycle 100 of the clear and again mid-RUN: the clear restarts for a full 256 cycles, prior data reads back as 0, and `sleep` is 0.

Source files
------------

// File: rtl/input_sample_buffer_if.sv
// Read/write bus of the multi-channel input sample buffer.
// master = serial front end / FIR engine side, slave = the buffer itself.
interface input_sample_buffer_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 8,
    parameter int CW     = 1
) ();
    logic              wr_En;
    logic [CW-1:0]     wr_Ch;
    logic [DATA_W-1:0] data_In;
    logic              rd_En;
    logic [CW-1:0]     rd_Ch;
    logic [AW-1:0]     rd_Offset;
    logic [DATA_W-1:0] data_Out;
    logic              data_Valid;
    logic              w_Done;

    modport master (
        output wr_En, wr_Ch, data_In, rd_En, rd_Ch, rd_Offset,
        input  data_Out, data_Valid, w_Done
    );

    modport slave (
        input  wr_En, wr_Ch, data_In, rd_En, rd_Ch, rd_Offset,
        output data_Out, data_Valid, w_Done
    );
endinterface

// File: rtl/input_sample_buffer.sv
// Multi-channel circular sample buffer read by sample age, with a self-clearing sequencer.
// Define INPUT_BUF_SLEEP_DET_EN to build the per-channel zero-run sleep detectors.
module input_sample_buffer #(
    parameter int  DATA_W       = 16,
    parameter int  DEPTH        = 256,
    parameter int  NCH          = 2,
    parameter int  SLEEP_THRESH = 800,
    localparam int AW           = $clog2(DEPTH),
    localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  sClk,
    input  logic                  reset,
    input  logic                  start,
    input_sample_buffer_if.slave  bus,
    output logic                  busy,
    output logic [NCH-1:0]        sleep,
    output logic                  sleep_All
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW:0]   NCH_LIM   = (CW + 1)'(NCH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) || (NCH < 1) ||
        (SLEEP_THRESH < 1) || (SLEEP_THRESH > 65535)) begin : g_bad_config
        $error("input_sample_buffer: illegal parameter set");
    end

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              restart;
    logic              clearing;
    logic              wr_ok;
    logic              rd_ok;
    logic [NCH-1:0][DATA_W-1:0] rd_word;
    logic [NCH-1:0]    sleep_bits;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              w_done_q;

    assign restart  = reset | start;
    assign clearing = (state_q == CLEAR);

    // Requests are only honoured in RUN and for channels that exist.
    assign wr_ok = (state_q == RUN) && !restart && bus.wr_En && ({1'b0, bus.wr_Ch} < NCH_LIM);
    assign rd_ok = (state_q == RUN) && !restart && bus.rd_En && ({1'b0, bus.rd_Ch} < NCH_LIM);

    always_ff @(posedge sClk) begin
        if (restart) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam logic [CW-1:0] CH_ID = CW'(g);

        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wr_ptr;
        logic              wr_hit;

        assign wr_hit = wr_ok && (bus.wr_Ch == CH_ID);

        always_ff @(posedge sClk) begin
            if (restart) begin
                wr_ptr <= '0;
            end else if (wr_hit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end

        // Clearing zeroes every slot, so ages older than the write history read as 0.
        always_ff @(posedge sClk) begin
            if (clearing) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_hit) begin
                mem[wr_ptr] <= bus.data_In;
            end
        end

        assign rd_word[g] = mem[wr_ptr - AW'(1) - bus.rd_Offset];

`ifdef INPUT_BUF_SLEEP_DET_EN
        localparam logic [15:0] THRESH16 = 16'(SLEEP_THRESH);
        logic [15:0] zero_cnt;

        always_ff @(posedge sClk) begin
            if (restart) begin
                zero_cnt <= '0;
            end else if (wr_hit) begin
                if (bus.data_In != '0) begin
                    zero_cnt <= '0;
                end else if (zero_cnt != THRESH16) begin
                    zero_cnt <= zero_cnt + 16'd1;
                end
            end
        end

        assign sleep_bits[g] = (zero_cnt == THRESH16);
`else
        assign sleep_bits[g] = 1'b0;
`endif
    end

    // The read sees the pre-write pointer and memory, so offset 0 is the previous newest.
    always_ff @(posedge sClk) begin
        if (restart) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            w_done_q     <= wr_ok;
            data_valid_q <= rd_ok;
            if (rd_ok) begin
                data_out_q <= rd_word[bus.rd_Ch];
            end
        end
    end

    assign bus.data_Out   = data_out_q;
    assign bus.data_Valid = data_valid_q;
    assign bus.w_Done     = w_done_q;
    assign sleep          = sleep_bits;
    assign sleep_All      = &sleep_bits;

endmodule

// File: tb/tb_input_sample_buffer.sv
// Directed self-checking bench for input_sample_buffer with default parameters.
// Sleep expectations follow INPUT_BUF_SLEEP_DET_EN; without it sleep must stay 0.
module tb_input_sample_buffer;

`ifdef INPUT_BUF_SLEEP_DET_EN
    localparam bit SLEEP_ON = 1'b1;
`else
    localparam bit SLEEP_ON = 1'b0;
`endif

    logic       sClk;
    logic       reset;
    logic       start;
    logic       busy;
    logic [1:0] sleep;
    logic       sleep_All;

    int compared   = 0;
    int mismatched = 0;

    input_sample_buffer_if #(.DATA_W(16), .AW(8), .CW(1)) bus ();

    input_sample_buffer #(
        .DATA_W(16), .DEPTH(256), .NCH(2), .SLEEP_THRESH(800)
    ) dut (
        .sClk      (sClk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .sleep     (sleep),
        .sleep_All (sleep_All)
    );

    initial sClk = 1'b0;
    always #5 sClk = ~sClk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sClk);
        #1;
    endtask

    // Drive one cycle of bus requests; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic we, input logic wch, input logic [15:0] din,
                                 input logic re, input logic rch, input logic [7:0] off);
        bus.wr_En     = we;
        bus.wr_Ch     = wch;
        bus.data_In   = din;
        bus.rd_En     = re;
        bus.rd_Ch     = rch;
        bus.rd_Offset = off;
        step();
        bus.wr_En = 1'b0;
        bus.rd_En = 1'b0;
    endtask

    // Counts samples with busy high, starting from a count already observed.
    task automatic waitClear(input int already, output int n);
        n = already;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!busy) break;
            n++;
        end
    endtask

    task automatic zeroRun(input logic ch, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, ch, 16'h0000, 1'b0, 1'b0, 8'd0);
        end
    endtask

    function automatic logic [31:0] expSleep(input logic [31:0] v);
        return SLEEP_ON ? v : 32'h0;
    endfunction

    initial begin
        int n;
        int wdoneCount;

        reset = 1'b1;
        start = 1'b0;
        bus.wr_En = 1'b0; bus.wr_Ch = 1'b0; bus.data_In = 16'h0;
        bus.rd_En = 1'b0; bus.rd_Ch = 1'b0; bus.rd_Offset = 8'd0;
        step();
        reset = 1'b0;
        $display("[TB] reset applied");

        checkOutput("reset busy",       32'(busy), 32'h1);
        checkOutput("reset data_Valid", 32'(bus.data_Valid), 32'h0);
        checkOutput("reset w_Done",     32'(bus.w_Done), 32'h0);
        checkOutput("reset data_Out",   32'(bus.data_Out), 32'h0);
        checkOutput("reset sleep",      32'(sleep), 32'h0);
        checkOutput("reset sleep_All",  32'(sleep_All), 32'h0);

        // Requests during CLEAR must be ignored.
        applyStimulus(1'b1, 1'b0, 16'h7777, 1'b1, 1'b0, 8'd0);
        checkOutput("clear w_Done",     32'(bus.w_Done), 32'h0);
        checkOutput("clear data_Valid", 32'(bus.data_Valid), 32'h0);
        waitClear(2, n);
        checkOutput("clear length", 32'(n), 32'd256);

        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd0);
        checkOutput("empty read data",  32'(bus.data_Out), 32'h0);
        checkOutput("empty read valid", 32'(bus.data_Valid), 32'h1);

        $display("[TB] writing ch0 samples 1..300");
        wdoneCount = 0;
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i), 1'b0, 1'b0, 8'd0);
            if (bus.w_Done) wdoneCount++;
        end
        checkOutput("w_Done pulses", 32'(wdoneCount), 32'd300);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0);
        checkOutput("w_Done idle", 32'(bus.w_Done), 32'h0);

        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd0);
        checkOutput("ch0 off0", 32'(bus.data_Out), 32'd300);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd1);
        checkOutput("ch0 off1", 32'(bus.data_Out), 32'd299);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd255);
        checkOutput("ch0 off255", 32'(bus.data_Out), 32'd45);
        checkOutput("ch0 off255 valid", 32'(bus.data_Valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0);
        checkOutput("hold data_Out", 32'(bus.data_Out), 32'd45);
        checkOutput("hold data_Valid", 32'(bus.data_Valid), 32'h0);

        $display("[TB] interleaved channel writes");
        applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd0);
        checkOutput("ch0 newest", 32'(bus.data_Out), 32'h1111);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'd0);
        checkOutput("ch1 newest", 32'(bus.data_Out), 32'h2222);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'd1);
        checkOutput("ch1 unwritten age", 32'(bus.data_Out), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd1);
        checkOutput("ch0 off1 after ch1", 32'(bus.data_Out), 32'd300);

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0, 8'd0);
        checkOutput("rw same cycle data", 32'(bus.data_Out), 32'h5555);
        checkOutput("rw same cycle w_Done", 32'(bus.w_Done), 32'h1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd0);
        checkOutput("read after rw", 32'(bus.data_Out), 32'hAAAA);

        $display("[TB] zero-run sleep detection");
        zeroRun(1'b1, 799);
        checkOutput("sleep at 799", 32'(sleep), 32'h0);
        zeroRun(1'b1, 1);
        checkOutput("sleep at 800", 32'(sleep), expSleep(32'h2));
        checkOutput("sleep_All one ch", 32'(sleep_All), 32'h0);
        zeroRun(1'b1, 3);
        checkOutput("sleep saturated", 32'(sleep), expSleep(32'h2));
        applyStimulus(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 8'd0);
        checkOutput("sleep cleared", 32'(sleep), 32'h0);
        zeroRun(1'b0, 800);
        checkOutput("sleep ch0", 32'(sleep), expSleep(32'h1));
        zeroRun(1'b1, 800);
        checkOutput("sleep both", 32'(sleep), expSleep(32'h3));
        checkOutput("sleep_All both", 32'(sleep_All), expSleep(32'h1));

        $display("[TB] start mid-RUN and mid-clear");
        start = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        checkOutput("start w_Done",     32'(bus.w_Done), 32'h0);
        checkOutput("start data_Valid", 32'(bus.data_Valid), 32'h0);
        checkOutput("start data_Out",   32'(bus.data_Out), 32'h0);
        checkOutput("start busy",       32'(busy), 32'h1);
        checkOutput("start sleep",      32'(sleep), 32'h0);
        for (int i = 0; i < 99; i++) step();
        checkOutput("busy before restart", 32'(busy), 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        waitClear(1, n);
        checkOutput("restarted clear length", 32'(n), 32'd256);

        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd0);
        checkOutput("ch0 cleared", 32'(bus.data_Out), 32'h0);
        checkOutput("ch0 cleared valid", 32'(bus.data_Valid), 32'h1);
        bus.data_In = 16'h0;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'd254);
        checkOutput("ch0 old age cleared", 32'(bus.data_Out), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'd0);
        checkOutput("ch1 cleared", 32'(bus.data_Out), 32'h0);
        checkOutput("sleep after restart", 32'(sleep), 32'h0);

        applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'd0);
        checkOutput("ch1 write after restart", 32'(bus.data_Out), 32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
